// File: rtl/zvc_line_scheduler_if.sv
// Requester / compressor / result-buffer bus of the ZVC line scheduler.
// master: line producers plus downstream credit return. slave: the scheduler.
interface zvc_line_scheduler_if #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned REQ_ID_W = 2
);
   logic [NUM_REQ-1:0]  req_valid;
   logic [NUM_REQ-1:0]  req_ready;
   logic                issue_valid;
   logic [REQ_ID_W-1:0] issue_sel;
   logic                res_valid;
   logic [REQ_ID_W-1:0] res_id;
   logic                credit_ret;

   modport master (
      output req_valid, credit_ret,
      input  req_ready, issue_valid, issue_sel, res_valid, res_id
   );

   modport slave (
      input  req_valid, credit_ret,
      output req_ready, issue_valid, issue_sel, res_valid, res_id
   );
endinterface

// File: rtl/zvc_line_scheduler.sv
// ZVC line scheduler: round-robin issue of producer lines into the fixed-latency
// compressor, credit-gated against the result buffer, with a flush/drain sequence.
// Optional macro ZVC_SCHED_PERF_EN adds perf_issued / perf_nocredit counters and perf_clr.
module zvc_line_scheduler #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned REQ_ID_W = 2,
   parameter int unsigned PIPE_LAT = 2,
   parameter int unsigned CREDITS  = 8,
   parameter int unsigned CREDIT_W = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   zvc_line_scheduler_if.slave  bus,
   input  logic                 flush_req,
   output logic                 flush_done,
   output logic                 busy,
   output logic [CREDIT_W-1:0]  credit_cnt,
   output logic                 credit_err
`ifdef ZVC_SCHED_PERF_EN
   ,
   input  logic                 perf_clr,
   output logic [31:0]          perf_issued,
   output logic [31:0]          perf_nocredit
`endif
);

   localparam int unsigned INF_W = $clog2(PIPE_LAT + 1);
   localparam logic [CREDIT_W-1:0] CREDITS_C = CREDIT_W'(CREDITS);
   localparam logic [REQ_ID_W-1:0] LAST_ID   = REQ_ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [REQ_ID_W-1:0] rr_q, rr_d;
   logic [REQ_ID_W-1:0] last_sel_q;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                err_q, err_d;
   logic [INF_W-1:0]    inflight_q, inflight_d;
   logic                flush_done_q, flush_done_d;
   logic                busy_q, busy_d;
   logic [PIPE_LAT-1:0] tag_vld_q;
   logic [REQ_ID_W-1:0] tag_id_q [PIPE_LAT];

   logic                grant_en;
   logic                grant;
   logic [REQ_ID_W-1:0] grant_idx;
   logic [NUM_REQ-1:0]  grant_oh;
   logic [REQ_ID_W-1:0] sel;
   logic                res_vld;
   logic                ret_ok;

   // Round-robin search: ids at/above the pointer first, then wrap to ids below it
   always_comb begin
      grant_en  = (state_q == S_RUN) && enable && (credit_q != '0);
      grant     = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant && grant_en && bus.req_valid[i] && (REQ_ID_W'(i) >= rr_q)) begin
            grant       = 1'b1;
            grant_idx   = REQ_ID_W'(i);
            grant_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant && grant_en && bus.req_valid[i] && (REQ_ID_W'(i) < rr_q)) begin
            grant       = 1'b1;
            grant_idx   = REQ_ID_W'(i);
            grant_oh[i] = 1'b1;
         end
      end
   end

   assign sel     = grant ? grant_idx : last_sel_q;
   assign res_vld = tag_vld_q[PIPE_LAT-1];

   // Credit, in-flight and round-robin pointer bookkeeping
   always_comb begin
      ret_ok = bus.credit_ret && (credit_q != CREDITS_C);
      err_d  = err_q | (bus.credit_ret && (credit_q == CREDITS_C));
      unique case ({grant, ret_ok})
         2'b10:   credit_d = credit_q - CREDIT_W'(1);
         2'b01:   credit_d = credit_q + CREDIT_W'(1);
         default: credit_d = credit_q;
      endcase
      unique case ({grant, res_vld})
         2'b10:   inflight_d = inflight_q + INF_W'(1);
         2'b01:   inflight_d = inflight_q - INF_W'(1);
         default: inflight_d = inflight_q;
      endcase
      rr_d = rr_q;
      if (grant) begin
         rr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + REQ_ID_W'(1);
      end
   end

   // Next-state and registered status outputs
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_RUN;
            if (flush_req) flush_done_d = 1'b1;
         end
         S_RUN: begin
            if (flush_req) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (inflight_d == '0) begin
               state_d      = S_IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) || (inflight_d != '0);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Counters, pointer, status flags and result tag pipe
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_q         <= '0;
         last_sel_q   <= '0;
         credit_q     <= CREDITS_C;
         err_q        <= 1'b0;
         inflight_q   <= '0;
         flush_done_q <= 1'b0;
         busy_q       <= 1'b0;
         tag_vld_q    <= '0;
         for (int s = 0; s < PIPE_LAT; s++) tag_id_q[s] <= '0;
      end else begin
         rr_q         <= rr_d;
         last_sel_q   <= sel;
         credit_q     <= credit_d;
         err_q        <= err_d;
         inflight_q   <= inflight_d;
         flush_done_q <= flush_done_d;
         busy_q       <= busy_d;
         tag_vld_q[0] <= grant;
         tag_id_q[0]  <= sel;
         for (int s = 1; s < PIPE_LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
         end
      end
   end

   assign bus.req_ready   = grant_oh;
   assign bus.issue_valid = grant;
   assign bus.issue_sel   = sel;
   assign bus.res_valid   = res_vld;
   assign bus.res_id      = tag_id_q[PIPE_LAT-1];
   assign flush_done      = flush_done_q;
   assign busy            = busy_q;
   assign credit_cnt      = credit_q;
   assign credit_err      = err_q;

`ifdef ZVC_SCHED_PERF_EN
   // Issued-line and credit-starved-cycle counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (!reset_n || perf_clr) begin
         perf_issued   <= '0;
         perf_nocredit <= '0;
      end else begin
         if (grant) perf_issued <= perf_issued + 32'd1;
         if ((state_q == S_RUN) && enable && (|bus.req_valid) && (credit_q == '0))
            perf_nocredit <= perf_nocredit + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_zvc_line_scheduler.sv
// Bench for zvc_line_scheduler: directed vector table, hand sequences for
// credit/flush/reset corners, and random traffic against a queue-based model.
module tb_zvc_line_scheduler;
   localparam int unsigned NUM_REQ  = 4;
   localparam int unsigned REQ_ID_W = 2;
   localparam int unsigned PIPE_LAT = 2;
   localparam int unsigned CREDITS  = 8;
   localparam int unsigned CREDIT_W = 4;

   logic                clk = 1'b0;
   logic                reset_n, enable, flush_req;
   logic                flush_done, busy, credit_err;
   logic [CREDIT_W-1:0] credit_cnt;
`ifdef ZVC_SCHED_PERF_EN
   logic                perf_clr = 1'b0;
   logic [31:0]         perf_issued, perf_nocredit;
`endif

   zvc_line_scheduler_if #(.NUM_REQ(NUM_REQ), .REQ_ID_W(REQ_ID_W)) bus ();

   zvc_line_scheduler #(
      .NUM_REQ(NUM_REQ), .REQ_ID_W(REQ_ID_W), .PIPE_LAT(PIPE_LAT),
      .CREDITS(CREDITS), .CREDIT_W(CREDIT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .bus        (bus),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .busy       (busy),
      .credit_cnt (credit_cnt),
      .credit_err (credit_err)
`ifdef ZVC_SCHED_PERF_EN
      ,
      .perf_clr      (perf_clr),
      .perf_issued   (perf_issued),
      .perf_nocredit (perf_nocredit)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // reference model: mode 0 idle, 1 run, 2 drain; results as a queue of due cycles
   typedef struct { int due; int id; } tag_t;
   tag_t m_q[$];
   int   m_mode, m_rr, m_last_sel, m_credits;
   bit   m_err, m_fd;

   // DUT outputs sampled in the most recent cycle
   logic [3:0] s_rdy;
   logic       s_iv, s_resv, s_fd, s_busy, s_err;
   logic [1:0] s_sel, s_resid;
   logic [3:0] s_cc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cycle(input bit rn, input bit en, input bit [3:0] rv, input bit cr, input bit fr);
      bit g, exp_rv, ret_ok;
      int g_idx;
      logic [3:0] exp_rdy;
      reset_n = rn; enable = en; bus.req_valid = rv; bus.credit_ret = cr; flush_req = fr;
      #1;
      g = 1'b0; g_idx = 0;
      if (m_mode == 1 && en && m_credits > 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (m_rr + k) % NUM_REQ;
            if (!g && ((rv >> c) & 4'b0001) != 4'b0000) begin g = 1'b1; g_idx = c; end
         end
      end
      exp_rdy = g ? (4'b0001 << g_idx) : 4'b0000;
      exp_rv  = (m_q.size() > 0) && (m_q[0].due == cyc);
      s_rdy = bus.req_ready; s_iv = bus.issue_valid; s_sel = bus.issue_sel;
      s_resv = bus.res_valid; s_resid = bus.res_id; s_fd = flush_done;
      s_busy = busy; s_cc = credit_cnt; s_err = credit_err;
      if (chk_en) begin
         check("m_req_ready", 32'(s_rdy), 32'(exp_rdy));
         check("m_issue_valid", 32'(s_iv), 32'(g));
         check("m_issue_sel", 32'(s_sel), 32'(g ? g_idx : m_last_sel));
         check("m_res_valid", 32'(s_resv), 32'(exp_rv));
         if (exp_rv) check("m_res_id", 32'(s_resid), 32'(m_q[0].id));
         check("m_flush_done", 32'(s_fd), 32'(m_fd));
         check("m_busy", 32'(s_busy), 32'((m_mode != 0) || (m_q.size() != 0)));
         check("m_credit_cnt", 32'(s_cc), 32'(m_credits));
         check("m_credit_err", 32'(s_err), 32'(m_err));
      end
      @(posedge clk);
      if (!rn) begin
         m_mode = 0; m_rr = 0; m_last_sel = 0; m_credits = CREDITS;
         m_err = 1'b0; m_fd = 1'b0; m_q.delete();
      end else begin
         ret_ok = cr && (m_credits != CREDITS);
         if (cr && m_credits == CREDITS) m_err = 1'b1;
         if (exp_rv) void'(m_q.pop_front());
         if (g) begin
            m_q.push_back('{cyc + PIPE_LAT, g_idx});
            m_rr = (g_idx + 1) % NUM_REQ;
            m_last_sel = g_idx;
         end
         m_credits = m_credits + (ret_ok ? 1 : 0) - (g ? 1 : 0);
         m_fd = 1'b0;
         case (m_mode)
            0: begin if (fr) m_fd = 1'b1; if (en) m_mode = 1; end
            1: if (fr) m_mode = 2;
            default: if (m_q.size() == 0) begin m_mode = 0; m_fd = 1'b1; end
         endcase
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   typedef struct {
      bit en; bit [3:0] rv; bit cr;
      bit [3:0] e_rdy; bit e_iv; int e_sel; bit e_resv; int e_resid; int e_cc; bit e_busy;
   } vec_t;
   vec_t vt[10];

   initial begin
      int n;
      // round-robin with all requesters valid, one credit returned per result
      vt[0] = '{0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 8, 0};
      vt[1] = '{1, 4'hF, 0, 4'h0, 0, 0, 0, 0, 8, 0};
      vt[2] = '{1, 4'hF, 0, 4'h1, 1, 0, 0, 0, 8, 1};
      vt[3] = '{1, 4'hF, 0, 4'h2, 1, 1, 0, 0, 7, 1};
      vt[4] = '{1, 4'hF, 1, 4'h4, 1, 2, 1, 0, 6, 1};
      vt[5] = '{1, 4'hF, 1, 4'h8, 1, 3, 1, 1, 6, 1};
      vt[6] = '{1, 4'hF, 1, 4'h1, 1, 0, 1, 2, 6, 1};
      vt[7] = '{0, 4'hF, 1, 4'h0, 0, 0, 1, 3, 6, 1};
      vt[8] = '{0, 4'hF, 1, 4'h0, 0, 0, 1, 0, 7, 1};
      vt[9] = '{0, 4'hF, 0, 4'h0, 0, 0, 0, 0, 8, 1};

      reset_n = 1'b0; enable = 1'b0; flush_req = 1'b0;
      bus.req_valid = '0; bus.credit_ret = 1'b0;
      @(negedge clk);
      do_reset();
      do_reset();
      chk_en = 1'b1;

      check("rst_res_id", 32'(bus.res_id), 32'd0);
      check("rst_credit_err", 32'(credit_err), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, vt[i].en, vt[i].rv, vt[i].cr, 1'b0);
         check("tv_req_ready", 32'(s_rdy), 32'(vt[i].e_rdy));
         check("tv_issue_valid", 32'(s_iv), 32'(vt[i].e_iv));
         check("tv_issue_sel", 32'(s_sel), 32'(vt[i].e_sel));
         check("tv_res_valid", 32'(s_resv), 32'(vt[i].e_resv));
         if (vt[i].e_resv) check("tv_res_id", 32'(s_resid), 32'(vt[i].e_resid));
         check("tv_credit_cnt", 32'(s_cc), 32'(vt[i].e_cc));
         check("tv_busy", 32'(s_busy), 32'(vt[i].e_busy));
      end

      // credit exhaustion and single-credit recovery
      do_reset();
      cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
         n += int'(s_iv);
      end
      check("exh_issue_count", 32'(n), 32'd8);
      check("exh_req_ready", 32'(s_rdy), 32'd0);
      check("exh_credit_cnt", 32'(s_cc), 32'd0);
      cycle(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
      check("exh_ret_cycle", 32'(s_iv), 32'd0);
      cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      check("exh_reissue", 32'(s_iv), 32'd1);
      cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      check("exh_one_only", 32'(s_iv), 32'd0);

      // simultaneous issue and return, then return at full credits
      do_reset();
      cycle(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
      check("sim_issue", 32'(s_iv), 32'd1);
      check("sim_cc_before", 32'(s_cc), 32'd5);
      cycle(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      check("sim_cc_after", 32'(s_cc), 32'd5);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
      check("full_cc", 32'(s_cc), 32'd8);
      check("full_err_before", 32'(s_err), 32'd0);
      cycle(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      check("full_cc_after", 32'(s_cc), 32'd8);
      check("full_err_sticky", 32'(s_err), 32'd1);

      // flush with two lines in flight
      do_reset();
      cycle(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      check("fl_issue_t", 32'(s_iv), 32'd1);
      cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b1);
      check("fl_issue_t1", 32'(s_iv), 32'd1);
      cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      check("fl_no_grant_t2", 32'(s_iv), 32'd0);
      check("fl_res_t2", 32'(s_resv), 32'd1);
      cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      check("fl_res_t3", 32'(s_resv), 32'd1);
      check("fl_done_t3", 32'(s_fd), 32'd0);
      cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      check("fl_done_t4", 32'(s_fd), 32'd1);
      check("fl_busy_t4", 32'(s_busy), 32'd0);
      check("fl_no_grant_t4", 32'(s_iv), 32'd0);

      // flush while idle
      do_reset();
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      check("idle_flush_done", 32'(s_fd), 32'd1);
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      check("idle_flush_pulse", 32'(s_fd), 32'd0);

      // reset right after an issue discards the line
      do_reset();
      cycle(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
      check("mid_issue", 32'(s_iv), 32'd1);
      do_reset();
      n = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
         n += int'(s_resv);
      end
      check("mid_no_result", 32'(n), 32'd0);
      check("mid_credit_cnt", 32'(s_cc), 32'd8);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0, 4'($urandom),
               $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
